// File: rtl/forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
//
// Operand-forwarding and load-use hazard controller for a five-stage MIPS
// pipeline.
//
// Internal tracking state:
//   EX stage  : ex_rd, ex_wr, ex_load
//   MEM stage : mem_rd, mem_wr
//
// The module registers the 2-bit selectors for the two ALU-operand muxes of
// the instruction that enters EX. Selector encoding:
//   00 = register file
//   01 = EX/MEM result
//   10 = MEM/WB result
//
// It also raises a combinational stall when the ID instruction reads the
// destination of a load that is still in EX.
//
// Optional feature macro: FWD_STALL_COUNT_EN adds the 16-bit saturating
// stall_count output and its counter.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset        in   synchronous, active-low
//   id_valid     in   ID holds a real instruction
//   id_rs/id_rt  in   source registers of the ID instruction
//   id_uses_rt   in   ID instruction reads rt as an operand
//   id_rd        in   destination register of the ID instruction
//   id_reg_write in   ID instruction writes the register file
//   id_mem_read  in   ID instruction is a load
//   flush        in   squash the ID instruction
//   fwd_a_sel    out  registered operand-A selector for the EX instruction
//   fwd_b_sel    out  registered operand-B selector for the EX instruction
//   stall        out  combinational load-use stall request
//   stall_count  out  saturating stall-cycle count (FWD_STALL_COUNT_EN only)
// ---------------------------------------------------------------------------
module forwarding_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    // Tracking state for the instructions currently in EX and MEM.
    logic [REG_ADDR_W-1:0] ex_rd_r;
    logic                  ex_wr_r;
    logic                  ex_load_r;
    logic [REG_ADDR_W-1:0] mem_rd_r;
    logic                  mem_wr_r;
    logic [1:0]            fwd_a_sel_r;
    logic [1:0]            fwd_b_sel_r;

    logic                  ex_hit_rs_s;
    logic                  ex_hit_rt_s;
    logic                  mem_hit_rs_s;
    logic                  mem_hit_rt_s;
    logic                  stall_s;
    logic                  bubble_s;
    logic [1:0]            fwd_a_next_s;
    logic [1:0]            fwd_b_next_s;

    // A producer matches when it writes, its destination is not $0, and the
    // destination equals the register being read.
    function automatic logic producer_hit(
        input logic                  wr,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] r
    );
        return wr && (rd != REG_ZERO) && (rd == r);
    endfunction

    // The EX match wins over the MEM match because it is the newer producer.
    function automatic logic [1:0] select_code(
        input logic ex_hit,
        input logic mem_hit
    );
        logic [1:0] code;
        if (ex_hit) begin
            code = SEL_EX;
        end else if (mem_hit) begin
            code = SEL_MEM;
        end else begin
            code = SEL_RF;
        end
        return code;
    endfunction

    // Hazard detection and next-selector computation.
    always_comb begin
        ex_hit_rs_s  = producer_hit(ex_wr_r, ex_rd_r, id_rs);
        ex_hit_rt_s  = producer_hit(ex_wr_r, ex_rd_r, id_rt);
        mem_hit_rs_s = producer_hit(mem_wr_r, mem_rd_r, id_rs);
        mem_hit_rt_s = producer_hit(mem_wr_r, mem_rd_r, id_rt);

        // A load's data is not available until it leaves MEM, so a consumer
        // directly behind it must wait one cycle. Flush cancels the request.
        stall_s  = id_valid && !flush && ex_load_r &&
                   (ex_hit_rs_s || (id_uses_rt && ex_hit_rt_s));
        bubble_s = stall_s || flush || !id_valid;

        fwd_a_next_s = select_code(ex_hit_rs_s, mem_hit_rs_s);
        if (id_uses_rt) begin
            fwd_b_next_s = select_code(ex_hit_rt_s, mem_hit_rt_s);
        end else begin
            fwd_b_next_s = SEL_RF;
        end
    end

    // Pipeline tracking registers and registered selectors.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_rd_r     <= REG_ZERO;
            ex_wr_r     <= 1'b0;
            ex_load_r   <= 1'b0;
            mem_rd_r    <= REG_ZERO;
            mem_wr_r    <= 1'b0;
            fwd_a_sel_r <= SEL_RF;
            fwd_b_sel_r <= SEL_RF;
        end else begin
            mem_rd_r <= ex_rd_r;
            mem_wr_r <= ex_wr_r;
            if (bubble_s) begin
                // A bubble writes nothing. ex_rd is left as-is because it is
                // ignored whenever ex_wr is 0.
                ex_wr_r     <= 1'b0;
                ex_load_r   <= 1'b0;
                fwd_a_sel_r <= SEL_RF;
                fwd_b_sel_r <= SEL_RF;
            end else begin
                ex_rd_r     <= id_rd;
                ex_wr_r     <= id_reg_write;
                ex_load_r   <= id_mem_read;
                fwd_a_sel_r <= fwd_a_next_s;
                fwd_b_sel_r <= fwd_b_next_s;
            end
        end
    end

    assign fwd_a_sel = fwd_a_sel_r;
    assign fwd_b_sel = fwd_b_sel_r;
    assign stall     = stall_s;

`ifdef FWD_STALL_COUNT_EN
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    logic [15:0] stall_count_r;

    // Saturating count of stall cycles seen outside reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_r <= 16'h0000;
        end else if (stall_s && (stall_count_r != STALL_CNT_MAX)) begin
            stall_count_r <= stall_count_r + 16'h0001;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// ---------------------------------------------------------------------------
// tb_forwarding_unit
//
// Scoreboard bench for forwarding_unit.
//
// The stimulus process drives one ID instruction per cycle. It asks an
// instruction-level pipeline model for two results and queues them:
//   - the expected stall for the current cycle;
//   - the expected selectors (and count) after the next edge.
//
// A separate monitor pops and compares both queues at fixed offsets from the
// rising edge.
// ---------------------------------------------------------------------------
module tb_forwarding_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
`ifdef FWD_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    forwarding_unit #(.REG_ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
`ifdef FWD_STALL_COUNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction-level model: what occupies EX and MEM.
    typedef struct {
        logic       writes;
        logic [4:0] dest;
        logic       is_load;
    } slot_t;

    slot_t       m_ex;
    slot_t       m_mem;
    logic [15:0] m_count;

    logic [19:0] sel_q[$];    // {count, a_sel, b_sel} expected after edge
    logic        stall_q[$];  // expected stall in the current cycle
    int          errors = 0;
    int          checks = 0;
    logic        last_stall;

    // Returns which stage supplies register r:
    //   0 = register file, 1 = EX (newest), 2 = MEM.
    function automatic int newest_producer(input logic [4:0] r);
        if (r == 5'd0) return 0;
        if (m_ex.writes && m_ex.dest == r) return 1;
        if (m_mem.writes && m_mem.dest == r) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] code_of(input int stage);
        if (stage == 1) return 2'b01;
        if (stage == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic issue(input logic rst, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ur, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic fl);
        logic       exp_stall;
        logic [1:0] ea;
        logic [1:0] eb;
        @(posedge clk);
        #2;
        reset        = rst;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = ur;
        id_rd        = rd;
        id_reg_write = wr;
        id_mem_read  = ld;
        flush        = fl;
        #1;

        // A consumer right behind a load must wait for the load to reach MEM.
        exp_stall = v && !fl && m_ex.is_load &&
                    (newest_producer(rs) == 1 || (ur && newest_producer(rt) == 1));
        ea = code_of(newest_producer(rs));
        eb = ur ? code_of(newest_producer(rt)) : 2'b00;

        if (!rst) begin
            m_ex    = '{1'b0, 5'd0, 1'b0};
            m_mem   = '{1'b0, 5'd0, 1'b0};
            m_count = 16'd0;
            ea      = 2'b00;
            eb      = 2'b00;
        end else begin
            m_mem = '{m_ex.writes, m_ex.dest, 1'b0};
            if (exp_stall || fl || !v) begin
                m_ex.writes  = 1'b0;
                m_ex.is_load = 1'b0;
                ea           = 2'b00;
                eb           = 2'b00;
            end else begin
                m_ex = '{wr, rd, ld};
            end
            if (exp_stall && m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end

        stall_q.push_back(exp_stall);
        sel_q.push_back({m_count, ea, eb});
        last_stall = exp_stall;
    endtask

    // Monitor: selectors just after each edge, stall once inputs have settled.
    initial begin
        logic [19:0] e;
        logic        es;
        forever begin
            @(posedge clk);
            #1;
            if (sel_q.size() > 0) begin
                e = sel_q.pop_front();
                checks++;
                if (fwd_a_sel !== e[3:2]) begin
                    errors++;
                    $display("FAIL fwd_a_sel t=%0t got=%b exp=%b", $time, fwd_a_sel, e[3:2]);
                end
                checks++;
                if (fwd_b_sel !== e[1:0]) begin
                    errors++;
                    $display("FAIL fwd_b_sel t=%0t got=%b exp=%b", $time, fwd_b_sel, e[1:0]);
                end
`ifdef FWD_STALL_COUNT_EN
                checks++;
                if (stall_count !== e[19:4]) begin
                    errors++;
                    $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, e[19:4]);
                end
`endif
            end
            #3;
            if (stall_q.size() > 0) begin
                es = stall_q.pop_front();
                checks++;
                if (stall !== es) begin
                    errors++;
                    $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, es);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        logic [4:0] rs, rt, rd;
        logic       v, ur, wr, ld, fl, rst;
        int         wait_cycles;

        reset = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
        m_ex = '{1'b0, 5'd0, 1'b0}; m_mem = '{1'b0, 5'd0, 1'b0}; m_count = 16'd0;
        last_stall = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with random inputs.
        repeat (2) issue(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                         5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        // EX forward: add $3 ; sub rs=$3.
        issue(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        // MEM forward: add $3 ; nop ; or $3,$3.
        issue(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        // Priority: add $3 ; add $3 ; dependent.
        issue(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        // Register zero never forwards.
        issue(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        // Load-use: lw $5 ; add rt=$5 held for the stall cycle.
        issue(1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 5'd2, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd2, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        // Flush on top of a load-use hazard.
        issue(1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 5'd2, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
        issue(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        // Back-to-back loads, then a dependent instruction.
        issue(1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 5'd6, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd6, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        // Reset in the middle of a stall.
        issue(1'b1, 1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        issue(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);

        // Randomized traffic over a small register set to provoke hazards.
        rs = 5'd0; rt = 5'd0; rd = 5'd0; v = 1'b0; ur = 1'b0; wr = 1'b0; ld = 1'b0;
        for (int i = 0; i < 600; i++) begin
            // A stalled instruction is usually presented again.
            if (!(last_stall && $urandom_range(0, 9) < 8)) begin
                v  = ($urandom_range(0, 99) < 85);
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                ur = 1'($urandom);
                rd = 5'($urandom_range(0, 7));
                wr = ($urandom_range(0, 9) < 8);
                ld = ($urandom_range(0, 9) < 4);
            end
            fl  = ($urandom_range(0, 9) == 0);
            rst = !($urandom_range(0, 59) == 0);
            issue(rst, v, rs, rt, ur, rd, wr, ld, fl);
        end

        // Let the monitor drain the queues.
        wait_cycles = 0;
        while ((sel_q.size() > 0 || stall_q.size() > 0) && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #5;
        checks++;
        if (sel_q.size() != 0 || stall_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sel_q.size() + stall_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forwarding_unit.md
# forwarding_unit

Sequential operand-forwarding and load-use hazard controller for the pipelined MIPS datapath. It tracks the destination register of the instructions in EX and MEM, and produces the registered 2-bit selectors for the two ALU-operand 3-to-1 multiplexers: 00 selects the register file, 01 the EX/MEM result, 10 the MEM/WB result. It asserts a stall request when the instruction in ID needs the result of a load that is still in EX.

## Interface
- REG_ADDR_W, default 5: register-address width.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_ADDR_W  source register A of the ID instruction.
- id_rt  input  REG_ADDR_W  source register B of the ID instruction.
- id_uses_rt  input  1  ID instruction reads rt as an operand.
- id_rd  input  REG_ADDR_W  destination register of the ID instruction (already muxed rt/rd/31).
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  squash the ID instruction (branch taken).
- fwd_a_sel  output  2  registered selector for the operand-A mux of the instruction in EX.
- fwd_b_sel  output  2  registered selector for the operand-B mux of the instruction in EX.
- stall  output  1  combinational; hold PC and IF/ID, insert a bubble into EX.
- stall_count  output  16  saturating count of stall cycles. Present only with FWD_STALL_COUNT_EN.

## Operation
- Internal tracking registers:
  - EX stage: ex_rd, ex_wr, ex_load.
  - MEM stage: mem_rd, mem_wr.
- Every edge, the MEM tracking registers take the EX values (mem_rd<=ex_rd, mem_wr<=ex_wr).
- ex_hit(r) = ex_wr && ex_rd!=0 && ex_rd==r.
- mem_hit(r) = mem_wr && mem_rd!=0 && mem_rd==r.
- stall = id_valid && !flush && ex_load && (ex_hit(id_rs) || (id_uses_rt && ex_hit(id_rt))).
- Bubble condition: stall || flush || !id_valid. On a bubble edge: ex_wr<=0, ex_load<=0, fwd_a_sel<=00, fwd_b_sel<=00.
- Otherwise, on the edge:
  - ex_rd<=id_rd, ex_wr<=id_reg_write, ex_load<=id_mem_read.
  - fwd_a_sel <= ex_hit(id_rs) ? 01 : mem_hit(id_rs) ? 10 : 00.
  - fwd_b_sel <= same rule applied to id_rt, gated by id_uses_rt (00 when id_uses_rt=0).
- Priority: an EX match beats a MEM match, because the newest producer wins.
- Register 0 never forwards.
- Encoding 11 is never produced.
- After a load-use stall, the load has moved to MEM. The held ID instruction then resolves with selector 10 on the next edge.

## Timing
- Reset (reset=0 at an edge) clears:
  - all tracking registers;
  - fwd_a_sel=00, fwd_b_sel=00;
  - stall_count=0.
- stall reads 0 while the tracking registers are cleared.
- Reset overrides all other inputs, including in the middle of a stall.
- Selector latency is one cycle: the selectors computed from ID inputs in cycle n are valid throughout cycle n+1, while that instruction is in EX.
- stall has zero latency (combinational from inputs and tracking state). It lasts exactly one cycle per load-use hazard.
- flush and stall together: flush wins, stall=0 and a bubble is inserted.
- Back-to-back loads with a dependent third instruction: one stall only, then 10 forwarding.

## Configuration
- FWD_STALL_COUNT_EN defined:
  - stall_count port exists.
  - It increments on each edge where stall=1 and reset=1.
  - It saturates at 16'hFFFF.
  - Reset clears it.
- FWD_STALL_COUNT_EN undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset=0 for 2 edges with random inputs -> fwd_a_sel=00, fwd_b_sel=00, stall=0, stall_count=0.
- EX forward: add $3 followed by sub using rs=$3 -> cycle after sub issue, fwd_a_sel=01, fwd_b_sel=00.
- MEM forward and priority:
  - add $3, nop, then or rs=rt=$3 -> both selectors 10.
  - add $3, add $3, then dependent -> 01 (EX wins).
- Register zero: producer writes $0, consumer reads $0 -> selectors 00.
- Load-use: lw $5, then add rt=$5 with id_uses_rt=1 -> stall=1 for exactly one cycle, bubble selectors 00, then fwd_b_sel=10. With the counter compiled in, stall_count=1.
- Flush during hazard: same as load-use but flush=1 -> stall=0, selectors 00, no tracking update.
